rng_sched: RTL and testbench

RNG_SCHED -- requirements
Module: rng_sched

---
 rtl/rng_sched_if.sv | 22 ++
 rtl/rng_sched.sv | 131 +++++++++++++
 tb/tb_rng_sched.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rng_sched_if.sv
// Request/grant and random-word bundle for the rng_sched block.
interface rng_sched_if #(
  parameter int N_REQ = 4
);
  logic [24:0]        seed;
  logic               seed_load;
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   gnt;
  logic               rand_valid;
  logic signed [24:0] rand_data;
  logic               busy;

  modport master (
    output seed, seed_load, req,
    input  gnt, rand_valid, rand_data, busy
  );

  modport slave (
    input  seed, seed_load, req,
    output gnt, rand_valid, rand_data, busy
  );
endinterface

// File: rtl/rng_sched.sv
// Round-robin scheduler handing out consecutive states of a 25-bit LFSR,
// one word per grant, with reseed and warm-up phases.
module rng_sched #(
  parameter int          N_REQ        = 4,
  parameter int          WARMUP       = 32,
  parameter logic [24:0] SEED_DEFAULT = 25'h1ACE1
) (
  input logic       clk,
  input logic       reset_n,
  rng_sched_if.slave bus
);

  localparam int          PW        = $clog2(N_REQ);
  localparam logic [PW:0] NREQ_W    = (PW+1)'(N_REQ);
  localparam logic [7:0]  WARM_LAST = 8'(WARMUP > 0 ? WARMUP - 1 : 0);

  typedef enum logic [1:0] {
    ST_SEED,
    ST_WARMUP,
    ST_SERVE
  } state_t;

  state_t            state_q, state_d;
  logic [24:0]       s_q, s_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              valid_q, valid_d;
  logic [24:0]       data_q, data_d;

  logic [24:0]       s_step;
  logic [24:0]       seed_fix;
  logic              pick_any;
  logic [PW-1:0]     pick_idx;
  logic [N_REQ-1:0]  pick_oh;

  // Polynomial x^25 + x^22 + 1; an all-zero seed would lock the LFSR.
  assign s_step   = {s_q[23:0], s_q[24] ^ s_q[21]};
  assign seed_fix = (bus.seed == 25'd0) ? 25'd1 : bus.seed;

  // Search starts one past the last granted requester and wraps.
  always_comb begin
    logic [PW:0] sum;
    sum      = '0;
    pick_any = 1'b0;
    pick_idx = ptr_q;
    pick_oh  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (sum >= NREQ_W) begin
        sum = sum - NREQ_W;
      end
      if (!pick_any && bus.req[sum[PW-1:0]]) begin
        pick_any = 1'b1;
        pick_idx = sum[PW-1:0];
      end
    end
    if (pick_any) begin
      pick_oh[pick_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    valid_d = 1'b0;
    data_d  = data_q;
    if (bus.seed_load) begin
      state_d = ST_SEED;
      s_d     = seed_fix;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        ST_SEED: begin
          cnt_d   = 8'd0;
          state_d = (WARMUP == 0) ? ST_SERVE : ST_WARMUP;
        end
        ST_WARMUP: begin
          if (WARMUP == 0) begin
            state_d = ST_SERVE;
          end else begin
            s_d   = s_step;
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == WARM_LAST) begin
              state_d = ST_SERVE;
            end
          end
        end
        ST_SERVE: begin
          if (pick_any) begin
            gnt_d   = pick_oh;
            valid_d = 1'b1;
            data_d  = s_q;
            s_d     = s_step;
            ptr_d   = pick_idx;
          end
        end
        default: state_d = ST_WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_WARMUP;
      s_q     <= SEED_DEFAULT;
      cnt_q   <= 8'd0;
      ptr_q   <= PW'(N_REQ - 1);
      gnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= 25'd0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.rand_valid = valid_q;
  assign bus.rand_data  = $signed(data_q);
  assign bus.busy       = (state_q != ST_SERVE);

endmodule

// File: tb/tb_rng_sched.sv
// Directed bench for rng_sched: one instance with WARMUP=32, one with WARMUP=0.
module tb_rng_sched;

  logic clk = 1'b0;
  logic reset_n;
  int   assertCount = 0;
  int   failCount   = 0;

  rng_sched_if #(.N_REQ(4)) busW ();
  rng_sched_if #(.N_REQ(4)) bus0 ();

  rng_sched #(.N_REQ(4), .WARMUP(32), .SEED_DEFAULT(25'h1ACE1)) dutW (
    .clk(clk), .reset_n(reset_n), .bus(busW)
  );
  rng_sched #(.N_REQ(4), .WARMUP(0), .SEED_DEFAULT(25'h1ACE1)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] lfsrNext(input logic [24:0] v);
    return {v[23:0], v[24] ^ v[21]};
  endfunction

  function automatic logic [24:0] lfsrSteps(input logic [24:0] v, input int n);
    logic [24:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = lfsrNext(r);
    return r;
  endfunction

  task test_reset;
    reset_n = 1'b0;
    busW.seed = '0; busW.seed_load = 1'b0; busW.req = '0;
    bus0.seed = '0; bus0.seed_load = 1'b0; bus0.req = '0;
    #12;
    assertCount++;
    if (busW.gnt !== 4'b0000) begin failCount++; $display("[TB] FAIL reset_gnt: got %b expected %b", busW.gnt, 4'b0000); end
    assertCount++;
    if (busW.rand_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %b expected 0", busW.rand_valid); end
    assertCount++;
    if (busW.rand_data !== 25'd0) begin failCount++; $display("[TB] FAIL reset_data: got %h expected 0", busW.rand_data); end
    assertCount++;
    if (busW.busy !== 1'b1) begin failCount++; $display("[TB] FAIL reset_busy: got %b expected 1", busW.busy); end
    assertCount++;
    if (bus0.busy !== 1'b1) begin failCount++; $display("[TB] FAIL reset_busy0: got %b expected 1", bus0.busy); end
  endtask

  task test_warmup;
    logic expBusy;
    logic [24:0] expData;
    reset_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      expBusy = (k < 32);
      assertCount++;
      if (busW.busy !== expBusy) begin failCount++; $display("[TB] FAIL warmup_busy k=%0d: got %b expected %b", k, busW.busy, expBusy); end
      assertCount++;
      if (busW.gnt !== 4'b0000) begin failCount++; $display("[TB] FAIL warmup_gnt k=%0d: got %b expected 0000", k, busW.gnt); end
      if (k == 1) begin
        assertCount++;
        if (bus0.busy !== 1'b0) begin failCount++; $display("[TB] FAIL warmup0_busy: got %b expected 0", bus0.busy); end
      end
    end
    busW.req = 4'b0001;
    expData = lfsrSteps(25'h1ACE1, 32);
    @(posedge clk); #1;
    assertCount++;
    if (busW.gnt !== 4'b0001) begin failCount++; $display("[TB] FAIL warmup_first_gnt: got %b expected 0001", busW.gnt); end
    assertCount++;
    if (busW.rand_data !== expData) begin failCount++; $display("[TB] FAIL warmup_first_data: got %h expected %h", busW.rand_data, expData); end
  endtask

  task test_round_robin;
    logic [24:0] expS;
    logic [3:0]  expGnt;
    expS = 25'h1ACE1;
    bus0.req = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 7) bus0.req = 4'b0101;
      if (i < 8) expGnt = 4'b0001 << (i % 4);
      else       expGnt = ((i % 2) == 0) ? 4'b0001 : 4'b0100;
      assertCount++;
      if (bus0.gnt !== expGnt) begin failCount++; $display("[TB] FAIL rr_gnt i=%0d: got %b expected %b", i, bus0.gnt, expGnt); end
      assertCount++;
      if (bus0.rand_data !== expS) begin failCount++; $display("[TB] FAIL rr_data i=%0d: got %h expected %h", i, bus0.rand_data, expS); end
      assertCount++;
      if (bus0.rand_valid !== 1'b1) begin failCount++; $display("[TB] FAIL rr_valid i=%0d: got %b expected 1", i, bus0.rand_valid); end
      expS = lfsrNext(expS);
    end
    bus0.req = 4'b0000;
  endtask

  task test_single;
    logic [24:0] expWords [3];
    expWords[0] = 25'h0000001; expWords[1] = 25'h0000002; expWords[2] = 25'h0000004;
    bus0.seed = 25'h0000001; bus0.seed_load = 1'b1; bus0.req = 4'b0001;
    @(posedge clk); #1;
    bus0.seed_load = 1'b0;
    assertCount++;
    if (bus0.gnt !== 4'b0000) begin failCount++; $display("[TB] FAIL single_seed_gnt: got %b expected 0000", bus0.gnt); end
    assertCount++;
    if (bus0.busy !== 1'b1) begin failCount++; $display("[TB] FAIL single_seed_busy: got %b expected 1", bus0.busy); end
    @(posedge clk); #1;
    assertCount++;
    if (bus0.gnt !== 4'b0000 || bus0.busy !== 1'b0) begin failCount++; $display("[TB] FAIL single_serve_entry: got gnt=%b busy=%b expected 0000/0", bus0.gnt, bus0.busy); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      assertCount++;
      if (bus0.gnt !== 4'b0001) begin failCount++; $display("[TB] FAIL single_gnt i=%0d: got %b expected 0001", i, bus0.gnt); end
      assertCount++;
      if (bus0.rand_data !== expWords[i]) begin failCount++; $display("[TB] FAIL single_data i=%0d: got %h expected %h", i, bus0.rand_data, expWords[i]); end
    end
    bus0.req = 4'b0000;
  endtask

  task test_zero_seed;
    bus0.seed = 25'h0000000; bus0.seed_load = 1'b1; bus0.req = 4'b0001;
    @(posedge clk); #1;
    bus0.seed_load = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    assertCount++;
    if (bus0.rand_data !== 25'h0000001) begin failCount++; $display("[TB] FAIL zero_seed_word0: got %h expected 0000001", bus0.rand_data); end
    @(posedge clk); #1;
    assertCount++;
    if (bus0.rand_data !== 25'h0000002) begin failCount++; $display("[TB] FAIL zero_seed_word1: got %h expected 0000002", bus0.rand_data); end
    bus0.req = 4'b0000;
  endtask

  task test_reseed_mid_warmup;
    logic [3:0]  expGnt;
    logic [24:0] expData;
    busW.seed = 25'h0ABCDE; busW.seed_load = 1'b1; busW.req = 4'b0001;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (k == 1) busW.seed_load = 1'b0;
      assertCount++;
      if (busW.busy !== 1'b1 || busW.gnt !== 4'b0000) begin failCount++; $display("[TB] FAIL reseed1 k=%0d: got busy=%b gnt=%b expected 1/0000", k, busW.busy, busW.gnt); end
    end
    busW.seed = 25'h1234567; busW.seed_load = 1'b1;
    expData = lfsrSteps(25'h1234567, 32);
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk); #1;
      if (k == 1) busW.seed_load = 1'b0;
      expGnt = (k == 35) ? 4'b0001 : 4'b0000;
      assertCount++;
      if (busW.busy !== (k <= 33)) begin failCount++; $display("[TB] FAIL reseed2_busy k=%0d: got %b expected %b", k, busW.busy, (k <= 33)); end
      assertCount++;
      if (busW.gnt !== expGnt) begin failCount++; $display("[TB] FAIL reseed2_gnt k=%0d: got %b expected %b", k, busW.gnt, expGnt); end
    end
    busW.req = 4'b0000;
    assertCount++;
    if (busW.rand_data !== expData) begin failCount++; $display("[TB] FAIL reseed2_data: got %h expected %h", busW.rand_data, expData); end
  endtask

  task test_seed_vs_grant;
    logic [3:0]  expGnt;
    logic [24:0] expData;
    busW.seed = 25'h0000ABC; busW.seed_load = 1'b1; busW.req = 4'b0010;
    expData = lfsrSteps(25'h0000ABC, 32);
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk); #1;
      if (k == 1) busW.seed_load = 1'b0;
      expGnt = (k == 35) ? 4'b0010 : 4'b0000;
      assertCount++;
      if (busW.gnt !== expGnt) begin failCount++; $display("[TB] FAIL seedgnt_gnt k=%0d: got %b expected %b", k, busW.gnt, expGnt); end
      if (k == 1 || k == 34) begin
        assertCount++;
        if (busW.busy !== (k == 1)) begin failCount++; $display("[TB] FAIL seedgnt_busy k=%0d: got %b expected %b", k, busW.busy, (k == 1)); end
      end
    end
    busW.req = 4'b0000;
    assertCount++;
    if (busW.rand_data !== expData) begin failCount++; $display("[TB] FAIL seedgnt_data: got %h expected %h", busW.rand_data, expData); end
  endtask

  task test_async_reset;
    bus0.req = 4'b0001;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    assertCount++;
    if (bus0.gnt !== 4'b0000 || bus0.rand_valid !== 1'b0) begin failCount++; $display("[TB] FAIL async_gnt: got gnt=%b valid=%b expected 0000/0", bus0.gnt, bus0.rand_valid); end
    assertCount++;
    if (bus0.rand_data !== 25'd0) begin failCount++; $display("[TB] FAIL async_data: got %h expected 0", bus0.rand_data); end
    assertCount++;
    if (bus0.busy !== 1'b1 || busW.busy !== 1'b1) begin failCount++; $display("[TB] FAIL async_busy: got %b/%b expected 1/1", bus0.busy, busW.busy); end
    @(negedge clk);
    reset_n = 1'b1;
    bus0.req = 4'b1111;
    @(posedge clk); #1;
    assertCount++;
    if (bus0.gnt !== 4'b0000 || bus0.busy !== 1'b0) begin failCount++; $display("[TB] FAIL async_restart: got gnt=%b busy=%b expected 0000/0", bus0.gnt, bus0.busy); end
    @(posedge clk); #1;
    assertCount++;
    if (bus0.gnt !== 4'b0001) begin failCount++; $display("[TB] FAIL async_ptr: got %b expected 0001", bus0.gnt); end
    assertCount++;
    if (bus0.rand_data !== 25'h1ACE1) begin failCount++; $display("[TB] FAIL async_lfsr: got %h expected 01ace1", bus0.rand_data); end
    bus0.req = 4'b0000;
  endtask

  initial begin
    test_reset;
    test_warmup;
    test_round_robin;
    test_single;
    test_zero_seed;
    test_reseed_mid_warmup;
    test_seed_vs_grant;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
